// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers of the core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam int CTRL_W_MAX = 32;
  localparam logic [CTRL_W_MAX-1:0] CTRL_NOP = '0;

  // Per-boundary widths: ID/EX carries rs1, rs2, imm; EX/MEM and MEM/WB carry two words plus rd.
  localparam int ID_EX_CTRL_W  = 5;
  localparam int ID_EX_DATA_W  = 96;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  function automatic occ_t occ_of(input logic main_valid, input logic skid_valid);
    if (skid_valid) return FULL;
    if (main_valid) return ONE;
    return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages through one stage register.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o
  );

  modport master (
    output in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid, ctrl and data with load and clear.
module pipe_entry_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear kills the entry but leaves the payload alone; only reset zeroes data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with flush; in_ready comes straight from a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  pipe_stage_skid_if.slave         bus,
  output logic [1:0]               occupancy_o
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  logic              main_load, main_clr, skid_load, skid_clr, main_from_skid;
  logic              accept, drain;
  occ_t              state;

  assign state  = occ_of(main_valid, skid_valid);
  assign accept = bus.in_valid_i & ~skid_valid;
  assign drain  = main_valid & bus.out_ready_i;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = accept;
        ONE: begin
          if (drain) begin
            main_load = accept;
            main_clr  = ~accept;
          end else begin
            skid_load = accept;
          end
        end
        FULL: begin
          if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : bus.in_ctrl_i;
  assign main_data_d = main_from_skid ? skid_data : bus.in_data_i;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr    (main_clr),
    .load   (main_load),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr    (skid_clr),
    .load   (skid_load),
    .ctrl_d (bus.in_ctrl_i),
    .data_d (bus.in_data_i),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  assign bus.in_ready_o  = ~skid_valid;
  assign bus.out_valid_o = main_valid;
  assign bus.out_ctrl_o  = main_valid ? main_ctrl : CTRL_NOP[CTRL_W-1:0];
  assign bus.out_data_o  = main_data;
  assign occupancy_o     = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: drivers queue accepted entries, a monitor checks drains.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occ_w;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(5)) bus ();

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .bus         (bus),
    .occupancy_o (occ_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got ctrl=%0h data=%0h, required no output",
                   bus.out_ctrl_o, bus.out_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_entry", {27'd0, bus.out_ctrl_o, bus.out_data_o}, {27'd0, e});
        end
      end
      if (!bus.out_valid_o) chk("bubble_ctrl_zero", 64'(bus.out_ctrl_o), 64'd0);
    end
  end

  task automatic send(input logic [4:0] c, input logic [31:0] d,
                      output int waited, output logic [1:0] occ);
    bit ok = 1'b0;
    waited = 0;
    occ    = 2'd0;
    bus.in_valid_i = 1'b1;
    bus.in_ctrl_i  = c;
    bus.in_data_i  = d;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok  = 1'b1;
        occ = occ_w;
        exp_q.push_back({c, d});
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: data %0h never accepted, required accept within 20 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    logic [1:0] o;
    bus.in_valid_i  = 1'b0;
    bus.in_ctrl_i   = '0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    idle(2);
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_out_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("rst_occupancy", 64'(occ_w),           64'd0);
    chk("rst_out_data",  64'(bus.out_data_o),  64'd0);
    @(posedge clk);
    #1;

    // streaming
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(5'(i + 1), 32'h10 + 32'(i), w, o);
      if (i > 0) chk("stream_occupancy", 64'(o), 64'd1);
    end
    idle(3);
    chk("stream_drained_occ", 64'(occ_w), 64'd0);

    // backpressure
    bus.out_ready_i = 1'b0;
    send(5'd0, 32'hA, w, o);
    send(5'd0, 32'hB, w, o);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'hC;
    @(negedge clk);
    chk("bp_in_ready",  64'(bus.in_ready_o),  64'd0);
    chk("bp_occupancy", 64'(occ_w),           64'd2);
    chk("bp_out_data",  64'(bus.out_data_o),  64'hA);
    @(posedge clk);
    #1;
    bus.in_data_i = 32'hEE;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_hold_ready", 64'(bus.in_ready_o), 64'd0);
    chk("bp_hold_data",  64'(bus.out_data_o), 64'hA);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    send(5'd0, 32'hC, w, o);
    chk("bp_recovery_wait", 64'(w), 64'd1);
    idle(3);
    chk("bp_drained_occ", 64'(occ_w), 64'd0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // flush while FULL with a concurrent input
    bus.out_ready_i = 1'b0;
    send(5'h1f, 32'h21, w, o);
    send(5'h1f, 32'h22, w, o);
    bus.in_valid_i = 1'b1;
    bus.in_ctrl_i  = 5'h1f;
    bus.in_data_i  = 32'h23;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_out_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    chk("flush_occupancy", 64'(occ_w),           64'd0);
    chk("flush_in_ready",  64'(bus.in_ready_o),  64'd1);
    idle(3);

    // reset and flush together while FULL
    bus.out_ready_i = 1'b0;
    send(5'd3, 32'h31, w, o);
    send(5'd3, 32'h32, w, o);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h33;
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("rstfl_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rstfl_out_ctrl",  64'(bus.out_ctrl_o),  64'd0);
    chk("rstfl_occupancy", 64'(occ_w),           64'd0);
    chk("rstfl_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("rstfl_out_data",  64'(bus.out_data_o),  64'd0);
    @(posedge clk);
    #1;
    send(5'd3, 32'h55, w, o);
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid_o), 64'd1);
    chk("post_rst_data",  64'(bus.out_data_o),  64'h55);
    @(posedge clk);
    #1;

    // single-entry turnover
    send(5'd2, 32'h61, w, o);
    send(5'd4, 32'h62, w, o);
    chk("turnover_occ_at_accept", 64'(o), 64'd1);
    @(negedge clk);
    chk("turnover_occupancy", 64'(occ_w),          64'd1);
    chk("turnover_out_data",  64'(bus.out_data_o), 64'h62);
    @(posedge clk);
    #1;
    idle(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline register. It generalises the fixed ID/EX, EX/MEM and MEM/WB stage registers into one reusable two-entry skid-buffered stage with a valid/ready handshake, a synchronous flush and bubble insertion. Every inter-stage boundary of the RISC-V core instantiates it, so stalls and branch flushes are handled in one place. Control bits are forced to zero on every bubble, so a squashed or empty slot can never write registers or memory.

## Interface
- `DATA_W`, 32: payload width (ALU result, store data, branch PC, write address, concatenated by the instantiating stage).
- `CTRL_W`, 5: control-bit width (RegWrite, Mem2Reg, branch, mem read, mem write, …). All zero means NOP.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush_i` input 1: synchronous kill of all held entries (branch taken, exception).
- `in_valid_i` input 1: upstream holds a valid entry.
- `in_ready_o` output 1: stage can accept. Registered, with no combinational path from `out_ready_i`.
- `in_ctrl_i` input CTRL_W: upstream control bits.
- `in_data_i` input DATA_W: upstream payload.
- `out_valid_o` output 1: the output entry is valid.
- `out_ready_i` input 1: downstream accepts this cycle.
- `out_ctrl_o` output CTRL_W: control bits. Zero whenever `out_valid_o`=0.
- `out_data_o` output DATA_W: payload. Its value is don't-care when invalid but holds its last value.
- `occupancy_o` output 2: number of held entries (0, 1 or 2).

## Operation
- Storage: a main register (drives the outputs) and a skid register. Each has a valid bit, a ctrl field and a data field.
- Accept happens when `in_valid_i` && `in_ready_o`. Drain happens when `out_valid_o` && `out_ready_i`.
- State machine, encoded by the valid bits:
  - EMPTY:
    - accept → ONE (main loaded).
  - ONE:
    - accept and drain → ONE (main reloaded).
    - accept without drain → FULL (skid loaded).
    - drain without accept → EMPTY.
    - neither → hold.
  - FULL (`in_ready_o`=0):
    - drain → ONE, with skid moved to main.
    - no drain → hold.
- `in_ready_o` = !skid_valid, taken from the register.
- Output order is strict FIFO. No entry is ever dropped or duplicated.
- Flush: the next state is EMPTY. Both valid bits and both ctrl fields are cleared, and an accept in the same cycle is discarded. Data fields are not cleared.
- Priority: `rst` > `flush_i` > normal handshake.
- Reset values:
  - `out_valid_o`=0, `out_ctrl_o`=0, `occupancy_o`=0, `in_ready_o`=1.
  - `out_data_o`=0 and skid data=0.
- `out_ctrl_o` is gated: main ctrl AND valid, so bubbles present all-zero control bits.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 entry per cycle while `out_ready_i`=1.
- Stall: `out_ready_i` low for k cycles with continuous input leaves `in_ready_o` low from the second stalled edge.
- Recovery: `in_ready_o` rises 1 cycle after the first drain from FULL.
- Flush asserted at edge N gives `out_valid_o`=0, `out_ctrl_o`=0 and `in_ready_o`=1 after edge N. The flush takes effect even while stalled.
- Reset mid-operation behaves exactly like a flush and additionally zeroes the data fields.
- `in_valid_i` may drop without an accept, and `in_data_i` may change while `in_ready_o`=0, because nothing is sampled unless the accept condition holds.

## Structure
- Shared package `pipe_pkg`:
  - occupancy state constants EMPTY, ONE and FULL.
  - a NOP control constant (all zero).
  - per-stage `CTRL_W`/`DATA_W` localparams for ID/EX, EX/MEM and MEM/WB.
- A single sub-module `pipe_entry_reg` (valid + ctrl + data with load and clear) is instantiated twice, for main and skid. The FSM and the muxing live at the top level.

## Test plan
- Reset, then idle:
  - response: `out_valid_o`=0, `out_ctrl_o`=0, `in_ready_o`=1, `occupancy_o`=0.
- Streaming: data 0x10, 0x11 and so on for 8 cycles with `out_ready_i`=1.
  - response: identical sequence out, 1-cycle latency, `occupancy_o` stays 1.
- Backpressure: `out_ready_i`=0 for 3 cycles while sending 0xA, 0xB, 0xC.
  - response: 0xA held on the output and 0xB in skid; `in_ready_o`=0 and 0xC is not accepted until ready.
  - on release the outputs are 0xA, 0xB, 0xC in order, none lost.
- Flush while FULL (ctrl=5'b11111), with a concurrent valid input.
  - response: next cycle `out_valid_o`=0, `out_ctrl_o`=0, `occupancy_o`=0, and the concurrent input is not emitted.
- `rst` and `flush_i` together with FULL, after which 0x55 is sent.
  - response: reset values first, then 0x55 emerges 1 cycle later.
- Single-entry turnover: in ONE, accept and drain in the same cycle.
  - response: occupancy stays 1 and the new data replaces the old data on the output.
